// File: rtl/gfx6_pkg.sv
// gfx6_pkg: shared definitions for the 6-bit-colour graphic framebuffer.
// Holds the framebuffer geometry, the pixel bit-field positions and the
// packer state encoding so the writer, the renderer and their benches
// agree on one layout.
package gfx6_pkg;

    localparam int LINE_BYTES = 180;
    localparam int LINES      = 150;
    localparam int FB_BYTES   = LINE_BYTES * LINES;
    localparam int NUM_GROUPS = FB_BYTES / 3;
    localparam int ADDR_W     = 15;
    localparam int GRP_W      = 14;
    localparam int PIX_W      = 6;

    // Pixel colour fields inside a 6-bit pixel {R1,R0,G1,G0,B1,B0}
    localparam int R_MSB = 5;
    localparam int R_LSB = 4;
    localparam int G_MSB = 3;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [0:0] {
        STREAM = 1'b0,
        FILL   = 1'b1
    } gfx6_state_t;

endpackage

// File: rtl/gfx6_pack_byte.sv
// gfx6_pack_byte: combinational byte former for the 4-pixels-in-3-bytes
// layout.
//   slot      : index of the incoming pixel within its group (1..3)
//   held      : the previous pixel of the group
//   pix       : the incoming pixel (forced to zero by the caller on flush)
//   pack_byte : the byte completed by that pixel
// Slot 0 completes no byte; the output is then zero.
module gfx6_pack_byte
    import gfx6_pkg::*;
(
    input  logic [1:0] slot,
    input  pixel_t     held,
    input  pixel_t     pix,
    output logic [7:0] pack_byte
);

    // Select which bits of the held and incoming pixels make up the byte
    always_comb begin
        pack_byte = 8'h00;
        case (slot)
            2'd1:    pack_byte = {held, pix[R_MSB:R_LSB]};
            2'd2:    pack_byte = {held[G_MSB:B_LSB], pix[R_MSB:G_LSB]};
            2'd3:    pack_byte = {held[B_MSB:B_LSB], pix};
            default: pack_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/graphic_pixel_packer.sv
// graphic_pixel_packer: host-side write stage of the graphic framebuffer.
// Packs a valid/ready stream of 6-bit pixels four-at-a-time into three VRAM
// bytes and offers a hardware fill-screen command.
//   clk, rst_n            : clock, asynchronous active-low reset
//   pix_valid/data/ready  : pixel stream handshake
//   set_addr, grp_addr    : load the write position (4-pixel group index)
//   flush                 : write out a partial group with zero padding
//   fill_start/fill_color : fill the whole framebuffer with one colour
//   busy                  : fill in progress
//   vram_we/waddr/wdata   : registered VRAM write port
module graphic_pixel_packer
    import gfx6_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [5:0]        pix_data,
    output logic              pix_ready,
    input  logic              set_addr,
    input  logic [13:0]       grp_addr,
    input  logic              flush,
    input  logic              fill_start,
    input  logic [5:0]        fill_color,
    output logic              busy,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [7:0]        vram_wdata
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FB_BYTES - 3);
    localparam logic [GRP_W-1:0]  GRP_LIMIT = GRP_W'(NUM_GROUPS);

    gfx6_state_t       state_r, state_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;          // byte address 3g of the current group
    logic [1:0]        slot_r, slot_s;        // pixel index in group (fill: byte phase 1..3)
    pixel_t            held_r, held_s;        // previous pixel of the group
    pixel_t            fill_color_r, fill_color_s;
    logic              ready_en_r;
    logic              busy_r, busy_s;
    logic              vram_we_r, we_s;
    logic [ADDR_W-1:0] vram_waddr_r, waddr_s;
    logic [7:0]        vram_wdata_r, wdata_s;

    logic              pix_ready_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] ptr_adv_s;
    logic [ADDR_W-1:0] grp_ptr_s;
    pixel_t            pk_held_s;
    pixel_t            pk_pix_s;
    logic [7:0]        pk_byte_s;

    gfx6_pack_byte u_pack (
        .slot      (slot_r),
        .held      (pk_held_s),
        .pix       (pk_pix_s),
        .pack_byte (pk_byte_s)
    );

    // Byte address of the byte completed in this slot, next group pointer, loaded group pointer
    always_comb begin
        wr_addr_s = ptr_r;
        case (slot_r)
            2'd2:    wr_addr_s = ptr_r + ADDR_W'(1);
            2'd3:    wr_addr_s = ptr_r + ADDR_W'(2);
            default: wr_addr_s = ptr_r;
        endcase
        if (ptr_r == LAST_PTR) begin
            ptr_adv_s = '0;
        end else begin
            ptr_adv_s = ptr_r + ADDR_W'(3);
        end
        // 3*g as g + 2*g; out-of-range groups restart at the top of the frame
        if (grp_addr >= GRP_LIMIT) begin
            grp_ptr_s = '0;
        end else begin
            grp_ptr_s = {1'b0, grp_addr} + {grp_addr, 1'b0};
        end
    end

    // Pack-byte operands: fill uses the fill colour for both, flush pads with zero
    always_comb begin
        pk_held_s = held_r;
        pk_pix_s  = pix_data;
        if (state_r == FILL) begin
            pk_held_s = fill_color_r;
            pk_pix_s  = fill_color_r;
        end else if (flush) begin
            pk_pix_s  = '0;
        end else begin
            pk_pix_s  = pix_data;
        end
    end

    // Next-state, write-port and handshake logic
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        slot_s       = slot_r;
        held_s       = held_r;
        fill_color_s = fill_color_r;
        we_s         = 1'b0;
        waddr_s      = vram_waddr_r;
        wdata_s      = vram_wdata_r;
        pix_ready_s  = ready_en_r && (state_r == STREAM) && !set_addr && !flush && !fill_start;

        case (state_r)
            STREAM: begin
                if (fill_start) begin
                    // Partial group is dropped; fill starts at byte 0, phase 1
                    state_s      = FILL;
                    fill_color_s = fill_color;
                    ptr_s        = '0;
                    slot_s       = 2'd1;
                    held_s       = '0;
                end else if (set_addr) begin
                    ptr_s  = grp_ptr_s;
                    slot_s = 2'd0;
                    held_s = '0;
                end else if (flush) begin
                    if (slot_r != 2'd0) begin
                        we_s    = 1'b1;
                        waddr_s = wr_addr_s;
                        wdata_s = pk_byte_s;
                        ptr_s   = ptr_adv_s;
                        slot_s  = 2'd0;
                        held_s  = '0;
                    end else begin
                        slot_s = slot_r;
                    end
                end else if (pix_valid && pix_ready_s) begin
                    held_s = pix_data;
                    if (slot_r == 2'd0) begin
                        slot_s = 2'd1;
                    end else begin
                        we_s    = 1'b1;
                        waddr_s = wr_addr_s;
                        wdata_s = pk_byte_s;
                        if (slot_r == 2'd3) begin
                            slot_s = 2'd0;
                            ptr_s  = ptr_adv_s;
                        end else begin
                            slot_s = slot_r + 2'd1;
                        end
                    end
                end else begin
                    slot_s = slot_r;
                end
            end
            FILL: begin
                we_s    = 1'b1;
                waddr_s = wr_addr_s;
                wdata_s = pk_byte_s;
                if (slot_r == 2'd3) begin
                    if (ptr_r == LAST_PTR) begin
                        state_s = STREAM;
                        ptr_s   = '0;
                        slot_s  = 2'd0;
                    end else begin
                        ptr_s   = ptr_r + ADDR_W'(3);
                        slot_s  = 2'd1;
                    end
                end else begin
                    slot_s = slot_r + 2'd1;
                end
            end
            default: begin
                state_s = STREAM;
                ptr_s   = '0;
                slot_s  = 2'd0;
                held_s  = '0;
            end
        endcase

        busy_s = (state_s == FILL);
    end

    // State, datapath and registered write-port update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= STREAM;
            ptr_r        <= '0;
            slot_r       <= 2'd0;
            held_r       <= '0;
            fill_color_r <= '0;
            ready_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            vram_we_r    <= 1'b0;
            vram_waddr_r <= '0;
            vram_wdata_r <= 8'h00;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            slot_r       <= slot_s;
            held_r       <= held_s;
            fill_color_r <= fill_color_s;
            ready_en_r   <= 1'b1;
            busy_r       <= busy_s;
            vram_we_r    <= we_s;
            vram_waddr_r <= waddr_s;
            vram_wdata_r <= wdata_s;
        end
    end

    assign pix_ready  = pix_ready_s;
    assign busy       = busy_r;
    assign vram_we    = vram_we_r;
    assign vram_waddr = vram_waddr_r;
    assign vram_wdata = vram_wdata_r;

endmodule
